csr_ctrl: RTL and testbench

Clocked machine-mode CSR unit with a sequencing FSM, replacing the combinational CSR path in the decode stage. It accepts one CSR or trap request at a time from IDU over a valid/ready handshake and performs a registered read-modify-write. It returns the old CSR value to the writeback path and issues a one-cycle PC redirect for ECALL and MRET. It owns mstatus, mtvec, mepc and mcause.

---
 rtl/csr_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_csr_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_ctrl
// Description : Machine-mode CSR unit. Sequenced read-modify-write of mstatus,
//               mtvec, mepc and mcause, plus ECALL/MRET PC redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(32'h0000_000b)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            illegal_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RW    = 3'd1;
  localparam logic [2:0] OP_RS    = 3'd2;
  localparam logic [2:0] OP_RC    = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]      state_q,  state_d;
  logic [2:0]      op_q,     op_d;
  logic [11:0]     addr_q,   addr_d;
  logic [XLEN-1:0] wdata_q,  wdata_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] old_q,    old_d;
  logic [XLEN-1:0] new_q,    new_d;
  logic            ill_q,    ill_d;
  logic            mie_q,    mie_d;
  logic            mpie_q,   mpie_d;
  logic [XLEN-1:0] mtvec_q,  mtvec_d;
  logic [XLEN-1:0] mepc_q,   mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ill_q, rsp_ill_d;
  logic            rdr_vld_q, rdr_vld_d;
  logic [XLEN-1:0] rdr_pc_q,  rdr_pc_d;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] csr_rd;
  logic            addr_ok;
  logic            write_en;

  // MPP is hardwired to machine mode; only MIE/MPIE are real storage.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  always_comb begin
    csr_rd  = '0;
    addr_ok = 1'b1;
    case (addr_q)
      A_MSTATUS: csr_rd = mstatus_rd;
      A_MTVEC:   csr_rd = mtvec_q;
      A_MEPC:    csr_rd = mepc_q;
      A_MCAUSE:  csr_rd = mcause_q;
      default:   addr_ok = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read and must not write.
  assign write_en = !ill_q && !(((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q == '0));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    old_d      = old_q;
    new_d      = new_q;
    ill_d      = ill_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_ill_d  = rsp_ill_q;
    rdr_vld_d  = 1'b0;
    rdr_pc_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = csr_op_i;
          addr_d  = csr_addr_i;
          wdata_d = wdata_i;
          pc_d    = pc_i;
          if (csr_op_i != OP_NOP) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        old_d = csr_rd;
        ill_d = !addr_ok;
        case (op_q)
          OP_RS:   new_d = csr_rd | wdata_q;
          OP_RC:   new_d = csr_rd & ~wdata_q;
          default: new_d = wdata_q;
        endcase
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        case (op_q)
          OP_RW, OP_RS, OP_RC: begin
            if (write_en) begin
              case (addr_q)
                A_MSTATUS: begin
                  mie_d  = new_q[3];
                  mpie_d = new_q[7];
                end
                A_MTVEC:  mtvec_d  = new_q & ALIGN_MASK;
                A_MEPC:   mepc_d   = new_q & ALIGN_MASK;
                A_MCAUSE: mcause_d = new_q;
                default: ;
              endcase
            end
            rsp_vld_d  = 1'b1;
            rsp_data_d = ill_q ? '0 : old_q;
            rsp_ill_d  = ill_q;
            state_d    = S_RESP;
          end
          OP_ECALL: begin
            mepc_d    = pc_q & ALIGN_MASK;
            mcause_d  = ECALL_CAUSE;
            mpie_d    = mie_q;
            mie_d     = 1'b0;
            rdr_vld_d = 1'b1;
            rdr_pc_d  = mtvec_q & ALIGN_MASK;
          end
          OP_MRET: begin
            mie_d     = mpie_q;
            mpie_d    = 1'b1;
            rdr_vld_d = 1'b1;
            rdr_pc_d  = mepc_q;
          end
          default: ;
        endcase
      end
      S_RESP: begin
        if (resp_ready_i) begin
          rsp_vld_d  = 1'b0;
          rsp_data_d = '0;
          rsp_ill_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
      ill_q      <= 1'b0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_ill_q  <= 1'b0;
      rdr_vld_q  <= 1'b0;
      rdr_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      new_q      <= new_d;
      ill_q      <= ill_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_ill_q  <= rsp_ill_d;
      rdr_vld_q  <= rdr_vld_d;
      rdr_pc_q   <= rdr_pc_d;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign resp_valid_o     = rsp_vld_q;
  assign resp_rdata_o     = rsp_data_q;
  assign illegal_o        = rsp_ill_q;
  assign redirect_valid_o = rdr_vld_q;
  assign redirect_pc_o    = rdr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_ctrl
// Description : Directed self-checking bench for csr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready_o;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        resp_valid_o;
  logic        resp_ready;
  logic [31:0] resp_rdata_o;
  logic        illegal_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  csr_ctrl #(.XLEN(32), .ECALL_CAUSE(32'h0000_000b)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .csr_op_i         (csr_op),
    .csr_addr_i       (csr_addr),
    .wdata_i          (wdata),
    .pc_i             (pc),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata_o),
    .illegal_o        (illegal_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] p);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    wdata     = wd;
    pc        = p;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    csr_op    = 3'd0;
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic csr_txn(input string tag, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
    issue(op, addr, wd, 32'h0);
    @(negedge clk);
    chk({tag, "_exec_ready"}, {31'd0, req_ready_o}, 32'd0);
    chk({tag, "_exec_vld"}, {31'd0, resp_valid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_commit_vld"}, {31'd0, resp_valid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, resp_valid_o}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata_o, exp_rd);
    chk({tag, "_ill"}, {31'd0, illegal_o}, {31'd0, exp_ill});
    chk({tag, "_no_rdr"}, {31'd0, redirect_valid_o}, 32'd0);
    accept_resp();
    @(negedge clk);
    chk({tag, "_drop_vld"}, {31'd0, resp_valid_o}, 32'd0);
    chk({tag, "_drop_data"}, resp_rdata_o, 32'd0);
  endtask

  task automatic trap_txn(input string tag, input logic [2:0] op,
                          input logic [31:0] p, input logic [31:0] exp_pc);
    issue(op, 12'h0, 32'h0, p);
    @(negedge clk);
    chk({tag, "_exec_rdr"}, {31'd0, redirect_valid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_commit_rdr"}, {31'd0, redirect_valid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_rdr"}, {31'd0, redirect_valid_o}, 32'd1);
    chk({tag, "_rdr_pc"}, redirect_pc_o, exp_pc);
    chk({tag, "_no_resp"}, {31'd0, resp_valid_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, redirect_valid_o}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    csr_op     = 3'd0;
    csr_addr   = 12'h0;
    wdata      = 32'h0;
    pc         = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_vld", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_ill", {31'd0, illegal_o}, 32'd0);
    chk("rst_rdr", {31'd0, redirect_valid_o}, 32'd0);
    chk("rst_rdr_pc", redirect_pc_o, 32'd0);
    reset = 1'b0;

    // mtvec write with low bits masked
    csr_txn("mtvec_rw", 3'd1, 12'h305, 32'h8000_0103, 32'h0, 1'b0);
    csr_txn("mtvec_rd", 3'd2, 12'h305, 32'h0, 32'h8000_0100, 1'b0);

    // mstatus set/clear of MIE, MPP reads as 11
    csr_txn("mst_set", 3'd2, 12'h300, 32'h8, 32'h1800, 1'b0);
    csr_txn("mst_clr", 3'd3, 12'h300, 32'h8, 32'h1808, 1'b0);
    csr_txn("mst_rd", 3'd2, 12'h300, 32'h0, 32'h1800, 1'b0);
    csr_txn("mst_set2", 3'd2, 12'h300, 32'h8, 32'h1800, 1'b0);

    // NOP is dropped: the next op still sees the same state
    issue(3'd0, 12'h300, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    chk("nop_ready", {31'd0, req_ready_o}, 32'd1);

    // ECALL
    trap_txn("ecall", 3'd4, 32'h8000_0044, 32'h8000_0100);
    csr_txn("ec_mepc", 3'd2, 12'h341, 32'h0, 32'h8000_0044, 1'b0);
    csr_txn("ec_mcause", 3'd2, 12'h342, 32'h0, 32'h0000_000b, 1'b0);
    csr_txn("ec_mst", 3'd2, 12'h300, 32'h0, 32'h1880, 1'b0);

    // MRET with a stalled back-to-back request
    issue(3'd5, 12'h0, 32'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    csr_op    = 3'd2;
    csr_addr  = 12'h300;
    wdata     = 32'h0;
    chk("b2b_exec_ready", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    chk("b2b_commit_ready", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    chk("mret_rdr", {31'd0, redirect_valid_o}, 32'd1);
    chk("mret_rdr_pc", redirect_pc_o, 32'h8000_0044);
    chk("b2b_idle_ready", {31'd0, req_ready_o}, 32'd1);
    chk("mret_no_resp", {31'd0, resp_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    csr_op    = 3'd0;
    @(negedge clk);
    chk("mret_pulse_end", {31'd0, redirect_valid_o}, 32'd0);
    chk("b2b_exec_vld", {31'd0, resp_valid_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_vld", {31'd0, resp_valid_o}, 32'd1);
    chk("b2b_mst", resp_rdata_o, 32'h1888);
    accept_resp();

    // Illegal address, response held under backpressure
    issue(3'd1, 12'h7C0, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ill_vld", {31'd0, resp_valid_o}, 32'd1);
      chk("ill_flag", {31'd0, illegal_o}, 32'd1);
      chk("ill_rdata", resp_rdata_o, 32'd0);
      chk("ill_ready", {31'd0, req_ready_o}, 32'd0);
    end
    accept_resp();
    @(negedge clk);
    chk("ill_drop_vld", {31'd0, resp_valid_o}, 32'd0);
    chk("ill_drop_flag", {31'd0, illegal_o}, 32'd0);
    csr_txn("ill_mst", 3'd2, 12'h300, 32'h0, 32'h1888, 1'b0);
    csr_txn("ill_mtvec", 3'd2, 12'h305, 32'h0, 32'h8000_0100, 1'b0);
    csr_txn("ill_mcause", 3'd2, 12'h342, 32'h0, 32'h0000_000b, 1'b0);

    // mepc alignment and full-width mcause
    csr_txn("mepc_rw", 3'd1, 12'h341, 32'h1234_5677, 32'h8000_0044, 1'b0);
    csr_txn("mepc_rd", 3'd2, 12'h341, 32'h0, 32'h1234_5674, 1'b0);
    csr_txn("mcause_rw", 3'd1, 12'h342, 32'hFFFF_FFFF, 32'h0000_000b, 1'b0);
    csr_txn("mcause_rc", 3'd3, 12'h342, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b0);
    csr_txn("mcause_rd", 3'd2, 12'h342, 32'h0, 32'hFFFF_FF0F, 1'b0);

    // Reset during COMMIT of an ECALL
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    csr_txn("r_mtvec", 3'd1, 12'h305, 32'h8000_0200, 32'h0, 1'b0);
    issue(3'd4, 12'h0, 32'h0, 32'h8000_0088);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rc_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rc_rdr", {31'd0, redirect_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("rc_rdr2", {31'd0, redirect_valid_o}, 32'd0);
    chk("rc_resp", {31'd0, resp_valid_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    csr_txn("rc_mepc", 3'd2, 12'h341, 32'h0, 32'h0, 1'b0);
    csr_txn("rc_mcause", 3'd2, 12'h342, 32'h0, 32'h0, 1'b0);
    csr_txn("rc_mst", 3'd2, 12'h300, 32'h0, 32'h1800, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
